flag_cond_reader: RTL and testbench
===================================

Name: flag_cond_reader

Overview:
- Consumer end of the system flag register: reads the 5-bit committed flags (oFLAG of the flag register) and evaluates branch/conditional-execute conditions for instructions in the issue stage.
- Tracks in-flight flag-writing instructions with a pending counter.
- Stalls any conditional instruction until every older flag write has committed.
- Emits one registered condition result per instruction toward the branch/commit stage.

Parameters:
- PEND_W, 3, width of the pending flag-writer counter; max outstanding writers = 2**PEND_W-1 (7).
- CC_W, 4, width of condition-code selector.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear (same effect as reset, one cycle)
- iFLAG  in  5  committed flags {SF,OF,CF,PF,ZF} = [4:0] order [4]SF [3]OF [2]CF [1]PF [0]ZF
- iFLAG_COMMIT  in  1  pulse: flag register latched a new writer's result this cycle
- iPREV_INST_VALID  in  1  instruction offered by previous stage
- iPREV_CC  in  4  condition selector of offered instruction
- iPREV_CC_USE  in  1  offered instruction is conditional (reads flags)
- iPREV_FLAG_WRITE  in  1  offered instruction will write flags
- oPREV_LOCK  out  1  back-pressure to previous stage
- iNEXT_LOCK  in  1  back-pressure from next stage
- oNEXT_VALID  out  1  result valid
- oNEXT_TAKEN  out  1  condition true (1 for unconditional)
- oNEXT_FLAG_WRITE  out  1  pass-through of writer bit
- oPEND_FULL  out  1  counter at max

Behaviour:
- Reset (inRESET=0, async) or iRESET_SYNC=1 (sync): state=IDLE, counter=0, oNEXT_VALID=0, oNEXT_TAKEN=0, oNEXT_FLAG_WRITE=0; oPREV_LOCK=0 during IDLE.
- Accept: iPREV_INST_VALID && !oPREV_LOCK.
- Counter: +1 on an accepted instruction with FLAG_WRITE; -1 on iFLAG_COMMIT; both in one cycle -> unchanged. Commit with counter=0 is ignored (no underflow). Accept of a writer with counter at max is blocked: oPREV_LOCK=1 whenever oPEND_FULL.
- States:
  - IDLE: on accept -> if CC_USE && (counter!=0) go WAIT, latch CC; else evaluate now and go OUT.
  - WAIT: oPREV_LOCK=1. Counter reaching 0 (including a commit this cycle taking it 1->0) -> evaluate in the following cycle on the newly committed iFLAG, go OUT.
  - OUT: oNEXT_VALID=1, outputs held stable while iNEXT_LOCK=1. When !iNEXT_LOCK: if a new accept occurs this cycle, apply the IDLE rule back-to-back; else go IDLE.
- Latency: unconditional or no-pending instruction -> result 1 cycle after accept. Waiting instruction -> result 1 cycle after the last commit (2 cycles after commit without FLAG_BYPASS_EN).
- oPREV_LOCK = WAIT || (OUT && iNEXT_LOCK) || oPEND_FULL.
- The writer itself does not wait on its own flags. A conditional writer waits only on older writers; its own increment applies at accept.
- Condition table (cc):
  - 0 always
  - 1 EQ Z
  - 2 NE !Z
  - 3 CS C
  - 4 CC !C
  - 5 MI S
  - 6 PL !S
  - 7 VS O
  - 8 VC !O
  - 9 HI C&!Z
  - 10 LS !C|Z
  - 11 GE S==O
  - 12 LT S!=O
  - 13 GT !Z&(S==O)
  - 14 LE Z|(S!=O)
  - 15 PE P

Optional Feature:
- FLAG_BYPASS_EN defined: in WAIT, when iFLAG_COMMIT takes the counter 1->0, evaluation uses iFLAG in that same cycle and the FSM goes directly to OUT, saving one cycle.
- Undefined: evaluation waits one extra cycle and uses the registered flags.

Decomposition:
- Shared package flag_pkg:
  - flag bit index constants (FLAG_ZF..FLAG_SF)
  - CC enum (CC_AL..CC_PE)
  - FSM state typedef (ST_IDLE, ST_WAIT, ST_OUT)
- One sub-module flag_cond_eval: purely combinational 4-bit cc + 5-bit flags -> taken. Shared with any future conditional-move unit.

Test Plan:
- Reset mid-WAIT: counter=2, state WAIT, pulse inRESET=0 -> all outputs 0, counter 0, oPREV_LOCK=0 immediately (async).
- No pending: flags=5'b00001, accept cc=1 (EQ) -> next cycle oNEXT_VALID=1, oNEXT_TAKEN=1. Repeat with cc=2 -> TAKEN=0.
- Dependency stall: accept writer, then conditional cc=12 (LT); hold oPREV_LOCK=1. Commit flags 5'b10000 -> result TAKEN=1, 1 cycle after commit with bypass, 2 cycles without.
- Simultaneous accept of a writer and iFLAG_COMMIT at counter=3 -> counter stays 3.
- Saturation: 7 writers accepted without commit -> oPEND_FULL=1, oPREV_LOCK=1. One commit -> lock drops.
- Output hold: OUT with iNEXT_LOCK=1 for 4 cycles while iFLAG changes -> oNEXT_TAKEN unchanged, and no new accept occurs.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag consumer: flag bit positions, condition
// codes and the condition-reader FSM states.
package flag_pkg;

    localparam int FLAG_W  = 5;
    localparam int FLAG_ZF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 3;
    localparam int FLAG_SF = 4;

    typedef enum logic [3:0] {
        CC_AL, CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS,
        CC_VC, CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_PE
    } cc_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } state_e;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluator: 4-bit condition code plus the five
// architectural flags -> condition true. No state, reusable by any unit
// that needs a flag predicate (e.g. a conditional-move path).
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [3:0]        iCC,
    input  logic [FLAG_W-1:0] iFLAG,
    output logic              oTAKEN
);

    logic s, o, c, p, z;

    assign s = iFLAG[FLAG_SF];
    assign o = iFLAG[FLAG_OF];
    assign c = iFLAG[FLAG_CF];
    assign p = iFLAG[FLAG_PF];
    assign z = iFLAG[FLAG_ZF];

    // Condition table lookup
    always_comb begin
        oTAKEN = 1'b1;
        case (cc_e'(iCC))
            CC_AL:   oTAKEN = 1'b1;
            CC_EQ:   oTAKEN = z;
            CC_NE:   oTAKEN = !z;
            CC_CS:   oTAKEN = c;
            CC_CC:   oTAKEN = !c;
            CC_MI:   oTAKEN = s;
            CC_PL:   oTAKEN = !s;
            CC_VS:   oTAKEN = o;
            CC_VC:   oTAKEN = !o;
            CC_HI:   oTAKEN = c && !z;
            CC_LS:   oTAKEN = !c || z;
            CC_GE:   oTAKEN = (s == o);
            CC_LT:   oTAKEN = (s != o);
            CC_GT:   oTAKEN = !z && (s == o);
            CC_LE:   oTAKEN = z || (s != o);
            CC_PE:   oTAKEN = p;
            default: oTAKEN = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_reader.sv
// Issue-stage flag consumer. Counts in-flight flag writers, holds any
// conditional instruction until all older writers have committed, then
// emits one registered taken/not-taken result per instruction.
// Optional macro FLAG_BYPASS_EN: a waiting instruction evaluates on the
// flags of the very commit that retires its last older writer (one cycle
// sooner); without it, evaluation happens the cycle after, on the
// registered flags.
module flag_cond_reader
    import flag_pkg::*;
#(
    parameter int PEND_W = 3,
    parameter int CC_W   = 4
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iRESET_SYNC,
    input  logic [FLAG_W-1:0] iFLAG,
    input  logic              iFLAG_COMMIT,
    input  logic              iPREV_INST_VALID,
    input  logic [CC_W-1:0]   iPREV_CC,
    input  logic              iPREV_CC_USE,
    input  logic              iPREV_FLAG_WRITE,
    output logic              oPREV_LOCK,
    input  logic              iNEXT_LOCK,
    output logic              oNEXT_VALID,
    output logic              oNEXT_TAKEN,
    output logic              oNEXT_FLAG_WRITE,
    output logic              oPEND_FULL
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q;
    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [CC_W-1:0]   cc_q;
    logic              wfw_q;      // waiting instruction is itself a writer
    logic              valid_q, taken_q, fw_q;

    logic              pend_full, lock, accept, inc, dec;
    logic [PEND_W-1:0] tgt;
    logic              at_tgt, wait_go;
    logic [CC_W-1:0]   eval_cc;
    logic              eval_hit, new_taken;

    assign pend_full = (cnt_q == PEND_MAX);
    assign lock      = (state_q == ST_WAIT) || ((state_q == ST_OUT) && iNEXT_LOCK) || pend_full;
    assign accept    = iPREV_INST_VALID && !lock;
    assign inc       = accept && iPREV_FLAG_WRITE;
    assign dec       = iFLAG_COMMIT && (cnt_q != '0);

    // A waiting writer already counted itself at accept, so it is released
    // when only its own entry remains (older writers commit in order).
    assign tgt    = {{(PEND_W-1){1'b0}}, wfw_q};
    assign at_tgt = (cnt_q == tgt);
`ifdef FLAG_BYPASS_EN
    assign wait_go = at_tgt || (dec && (cnt_q == tgt + PEND_W'(1)));
`else
    assign wait_go = at_tgt;
`endif

    // One evaluator: the latched code while waiting, otherwise the offered one
    assign eval_cc   = (state_q == ST_WAIT) ? cc_q : iPREV_CC;
    assign new_taken = iPREV_CC_USE ? eval_hit : 1'b1;

    flag_cond_eval u_eval (
        .iCC    (eval_cc),
        .iFLAG  (iFLAG),
        .oTAKEN (eval_hit)
    );

    // Pending-writer counter next state; commit at zero is dropped
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec)
            cnt_d = cnt_q + PEND_W'(1);
        else if (dec && !inc)
            cnt_d = cnt_q - PEND_W'(1);
    end

    // Issue FSM with registered result outputs
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cc_q    <= '0;
            wfw_q   <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            fw_q    <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cc_q    <= '0;
            wfw_q   <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            fw_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_WAIT: begin
                    if (wait_go) begin
                        state_q <= ST_OUT;
                        valid_q <= 1'b1;
                        taken_q <= eval_hit;
                        fw_q    <= wfw_q;
                    end
                end
                default: begin
                    if (state_q == ST_OUT && iNEXT_LOCK) begin
                        // hold result until the next stage takes it
                    end else if (accept) begin
                        if (iPREV_CC_USE && (cnt_q != '0)) begin
                            state_q <= ST_WAIT;
                            cc_q    <= iPREV_CC;
                            wfw_q   <= iPREV_FLAG_WRITE;
                            valid_q <= 1'b0;
                            taken_q <= 1'b0;
                            fw_q    <= 1'b0;
                        end else begin
                            state_q <= ST_OUT;
                            valid_q <= 1'b1;
                            taken_q <= new_taken;
                            fw_q    <= iPREV_FLAG_WRITE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        taken_q <= 1'b0;
                        fw_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign oPREV_LOCK       = lock;
    assign oNEXT_VALID      = valid_q;
    assign oNEXT_TAKEN      = taken_q;
    assign oNEXT_FLAG_WRITE = fw_q;
    assign oPEND_FULL       = pend_full;

endmodule

// File: tb/tb_flag_cond_reader.sv
// Bench for flag_cond_reader: reset checks, a table of single-instruction
// condition vectors, hand sequences for stall/saturation/hold/reset, then
// random traffic against a cycle-arithmetic reference model.
module tb_flag_cond_reader;

`ifdef FLAG_BYPASS_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic       iCLOCK = 1'b0;
    logic       inRESET, iRESET_SYNC;
    logic [4:0] iFLAG;
    logic       iFLAG_COMMIT, iPREV_INST_VALID, iPREV_CC_USE, iPREV_FLAG_WRITE;
    logic [3:0] iPREV_CC;
    logic       iNEXT_LOCK;
    logic       oPREV_LOCK, oNEXT_VALID, oNEXT_TAKEN, oNEXT_FLAG_WRITE, oPEND_FULL;

    flag_cond_reader dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iFLAG(iFLAG), .iFLAG_COMMIT(iFLAG_COMMIT),
        .iPREV_INST_VALID(iPREV_INST_VALID), .iPREV_CC(iPREV_CC),
        .iPREV_CC_USE(iPREV_CC_USE), .iPREV_FLAG_WRITE(iPREV_FLAG_WRITE),
        .oPREV_LOCK(oPREV_LOCK), .iNEXT_LOCK(iNEXT_LOCK),
        .oNEXT_VALID(oNEXT_VALID), .oNEXT_TAKEN(oNEXT_TAKEN),
        .oNEXT_FLAG_WRITE(oNEXT_FLAG_WRITE), .oPEND_FULL(oPEND_FULL)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Condition truth straight from the condition table
    function automatic logic cond(input logic [3:0] cc, input logic [4:0] f);
        logic s, o, c, p, z;
        {s, o, c, p, z} = f;
        case (cc)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return c;
            4'd4:  return !c;
            4'd5:  return s;
            4'd6:  return !s;
            4'd7:  return o;
            4'd8:  return !o;
            4'd9:  return c & !z;
            4'd10: return !c | z;
            4'd11: return s == o;
            4'd12: return s != o;
            4'd13: return !z & (s == o);
            4'd14: return z | (s != o);
            default: return p;
        endcase
    endfunction

    task automatic tick();
        @(negedge iCLOCK);
    endtask

    task automatic quiet();
        iFLAG_COMMIT = 0; iPREV_INST_VALID = 0; iPREV_CC_USE = 0;
        iPREV_FLAG_WRITE = 0; iPREV_CC = 0; iNEXT_LOCK = 0; iRESET_SYNC = 0;
    endtask

    task automatic offer(input logic [3:0] cc, input logic use_cc, input logic fw);
        iPREV_INST_VALID = 1; iPREV_CC = cc; iPREV_CC_USE = use_cc; iPREV_FLAG_WRITE = fw;
    endtask

    typedef struct {
        logic [4:0] flags;
        logic [3:0] cc;
        logic       use_cc;
        logic       exp;
    } vec_t;

    vec_t tbl[14];

    // reference model state
    int   m_cnt, m_older, m_zero, m_acc, cyc;
    logic m_wt, m_out, m_taken, m_fw, m_wfw, m_lock;
    logic [3:0] m_cc;

    initial begin
        int lat;
        logic ce, acc;
        quiet();
        iFLAG = 0;
        inRESET = 0;
        repeat (2) tick();
        chk("rst_valid", oNEXT_VALID, 0);
        chk("rst_taken", oNEXT_TAKEN, 0);
        chk("rst_fw", oNEXT_FLAG_WRITE, 0);
        chk("rst_lock", oPREV_LOCK, 0);
        chk("rst_full", oPEND_FULL, 0);
        inRESET = 1;
        tick();

        // single instruction, nothing pending: result one cycle after accept
        tbl[0]  = '{5'b00001, 4'd1,  1, 1};
        tbl[1]  = '{5'b00001, 4'd2,  1, 0};
        tbl[2]  = '{5'b00100, 4'd9,  1, 1};
        tbl[3]  = '{5'b00101, 4'd9,  1, 0};
        tbl[4]  = '{5'b10000, 4'd11, 1, 0};
        tbl[5]  = '{5'b11000, 4'd11, 1, 1};
        tbl[6]  = '{5'b11000, 4'd13, 1, 1};
        tbl[7]  = '{5'b11001, 4'd14, 1, 1};
        tbl[8]  = '{5'b00010, 4'd15, 1, 1};
        tbl[9]  = '{5'b00000, 4'd15, 1, 0};
        tbl[10] = '{5'b00000, 4'd0,  1, 1};
        tbl[11] = '{5'b00001, 4'd2,  0, 1};
        tbl[12] = '{5'b00100, 4'd4,  1, 0};
        tbl[13] = '{5'b01000, 4'd7,  1, 1};
        for (int i = 0; i < 14; i++) begin
            iFLAG = tbl[i].flags;
            offer(tbl[i].cc, tbl[i].use_cc, 0);
            tick();
            quiet();
            chk("tbl_valid", oNEXT_VALID, 1);
            chk($sformatf("tbl_taken[%0d]", i), oNEXT_TAKEN, tbl[i].exp);
            tick();
            chk("tbl_idle", oNEXT_VALID, 0);
        end

        // dependency stall: writer then LT waits for its commit
        iFLAG = 5'b00000;
        offer(0, 0, 1);
        tick();
        offer(4'd12, 1, 0);
        #1 chk("dep_accept_lock", oPREV_LOCK, 0);
        tick();
        quiet();
        chk("dep_wait_lock", oPREV_LOCK, 1);
        chk("dep_wait_valid", oNEXT_VALID, 0);
        tick();
        chk("dep_wait_lock2", oPREV_LOCK, 1);
        iFLAG = 5'b10000;
        iFLAG_COMMIT = 1;
        lat = 0;
        do begin
            tick();
            iFLAG_COMMIT = 0;
            lat++;
        end while (!oNEXT_VALID && lat < 6);
        chk("dep_latency", 8'(lat), 8'(1 + OFF));
        chk("dep_taken", oNEXT_TAKEN, 1);
        chk("dep_fw", oNEXT_FLAG_WRITE, 0);
        tick();

        // simultaneous writer accept + commit at count 3, then saturate
        offer(0, 0, 1);
        repeat (3) tick();
        iFLAG_COMMIT = 1;
        tick();
        iFLAG_COMMIT = 0;
        repeat (3) tick();
        chk("sat_full_at6", oPEND_FULL, 0);
        tick();
        chk("sat_full_at7", oPEND_FULL, 1);
        chk("sat_lock", oPREV_LOCK, 1);
        tick();
        chk("sat_blocked", oNEXT_VALID, 0);
        chk("sat_still_full", oPEND_FULL, 1);
        quiet();
        iFLAG_COMMIT = 1;
        tick();
        iFLAG_COMMIT = 0;
        chk("sat_full_drop", oPEND_FULL, 0);
        chk("sat_lock_drop", oPREV_LOCK, 0);
        iFLAG_COMMIT = 1;
        repeat (6) tick();
        iFLAG_COMMIT = 0;

        // output hold under next-stage lock while flags move
        iFLAG = 5'b00001;
        offer(4'd1, 1, 0);
        iNEXT_LOCK = 1;
        tick();
        offer(4'd2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            iFLAG = 5'b10110 ^ 5'(i << 1);
            #1;
            chk("hold_valid", oNEXT_VALID, 1);
            chk("hold_taken", oNEXT_TAKEN, 1);
            chk("hold_lock", oPREV_LOCK, 1);
            tick();
        end
        quiet();
        #1 chk("hold_release_lock", oPREV_LOCK, 0);
        tick();
        chk("hold_no_accept", oNEXT_VALID, 0);
        chk("hold_no_count", oPEND_FULL, 0);

        // async reset in the middle of a wait with two writers pending
        offer(0, 0, 1);
        repeat (2) tick();
        offer(4'd1, 1, 0);
        tick();
        quiet();
        chk("arst_pre_lock", oPREV_LOCK, 1);
        #2 inRESET = 0;
        #1;
        chk("arst_valid", oNEXT_VALID, 0);
        chk("arst_taken", oNEXT_TAKEN, 0);
        chk("arst_lock", oPREV_LOCK, 0);
        chk("arst_full", oPEND_FULL, 0);
        #1 inRESET = 1;
        tick();
        iFLAG = 5'b00001;
        offer(4'd1, 1, 0);
        tick();
        quiet();
        chk("arst_cnt_zero", oNEXT_VALID, 1);
        tick();

        // synchronous clear out of a wait
        offer(0, 0, 1);
        tick();
        offer(4'd2, 1, 0);
        tick();
        quiet();
        iRESET_SYNC = 1;
        tick();
        iRESET_SYNC = 0;
        chk("srst_lock", oPREV_LOCK, 0);
        chk("srst_valid", oNEXT_VALID, 0);
        offer(4'd2, 1, 0);
        tick();
        quiet();
        chk("srst_cnt_zero", oNEXT_VALID, 1);
        tick();

        // random traffic against the reference model
        m_cnt = 0; m_wt = 0; m_out = 0; m_taken = 0; m_fw = 0; m_wfw = 0;
        m_older = 0; m_zero = -1; m_acc = 0; m_cc = 0; cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_valid", oNEXT_VALID, m_out);
            if (m_out) begin
                chk("rnd_taken", oNEXT_TAKEN, m_taken);
                chk("rnd_fw", oNEXT_FLAG_WRITE, m_fw);
            end
            chk("rnd_full", oPEND_FULL, m_cnt == 7);
            iFLAG            = 5'($urandom);
            iPREV_CC         = 4'($urandom);
            iPREV_INST_VALID = ($urandom_range(0, 99) < 55);
            iPREV_CC_USE     = ($urandom_range(0, 99) < 60);
            iPREV_FLAG_WRITE = ($urandom_range(0, 99) < 50);
            iFLAG_COMMIT     = ($urandom_range(0, 99) < 30);
            iNEXT_LOCK       = ($urandom_range(0, 99) < 30);
            #1;
            m_lock = m_wt || (m_out && iNEXT_LOCK) || (m_cnt == 7);
            chk("rnd_lock", oPREV_LOCK, m_lock);
            ce  = iFLAG_COMMIT && (m_cnt > 0);
            acc = iPREV_INST_VALID && !m_lock;
            if (m_wt) begin
                if (ce) begin
                    m_older--;
                    if (m_older == 0) m_zero = cyc;
                end
                if (m_zero >= 0 && cyc >= m_zero + OFF && cyc > m_acc) begin
                    m_wt = 0; m_out = 1;
                    m_taken = cond(m_cc, iFLAG);
                    m_fw = m_wfw;
                end
            end else if (!(m_out && iNEXT_LOCK)) begin
                m_out = 0;
                if (acc) begin
                    if (iPREV_CC_USE && m_cnt != 0) begin
                        m_wt = 1; m_acc = cyc; m_cc = iPREV_CC; m_wfw = iPREV_FLAG_WRITE;
                        m_older = m_cnt - int'(ce);
                        m_zero = (m_older == 0) ? cyc : -1;
                    end else begin
                        m_out = 1;
                        m_taken = iPREV_CC_USE ? cond(iPREV_CC, iFLAG) : 1'b1;
                        m_fw = iPREV_FLAG_WRITE;
                    end
                end
            end
            m_cnt = m_cnt + int'(acc && iPREV_FLAG_WRITE) - int'(ce);
            cyc++;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
